// File: rtl/pic_8259a_pkg.sv
// Shared constants for the 8259A-compatible interrupt controller:
// init-sequence states, OCW2 command codes and the INTA vector format.
package pic_8259a_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ICW2  = 3'd1;
    localparam logic [2:0] ST_ICW3  = 3'd2;
    localparam logic [2:0] ST_ICW4  = 3'd3;
    localparam logic [2:0] ST_READY = 3'd4;

    // OCW2 {R, SL, EOI} field
    typedef enum logic [2:0] {
        OCW2_ROT_AEOI_CLR = 3'b000,
        OCW2_NS_EOI       = 3'b001,
        OCW2_NOP          = 3'b010,
        OCW2_S_EOI        = 3'b011,
        OCW2_ROT_AEOI_SET = 3'b100,
        OCW2_ROT_NS_EOI   = 3'b101,
        OCW2_SET_PRIO     = 3'b110,
        OCW2_ROT_S_EOI    = 3'b111
    } ocw2_cmd_t;

    function automatic logic [7:0] compose_vector(input logic [4:0] base, input logic [2:0] level);
        return {base, level};
    endfunction

endpackage

// File: rtl/pic_8259a_if.sv
// CPU-side strobes, request lines and INT output of the 8259A controller.
interface pic_8259a_if;

    logic       cs_neg;
    logic       rd_neg;
    logic       wr_neg;
    logic       a0;
    logic       sp_neg;
    logic       inta_neg;
    logic [0:7] ir;
    logic       interrupt_flag;

    modport master (output cs_neg, rd_neg, wr_neg, a0, sp_neg, inta_neg, ir,
                    input  interrupt_flag);

    modport slave  (input  cs_neg, rd_neg, wr_neg, a0, sp_neg, inta_neg, ir,
                    output interrupt_flag);

endinterface

// File: rtl/pic_priority_resolver.sv
// Rotating-priority encoder: finds the best unmasked request and the best
// in-service level, ranked from the level just above the lowest-priority pointer.
module pic_priority_resolver (
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic [7:0] isr,
    input  logic [2:0] lowest,
    output logic       int_req,
    output logic [2:0] req_level,
    output logic       isr_valid,
    output logic [2:0] isr_level
);

    logic [7:0] pending;
    logic       req_valid;
    logic [2:0] req_rank;
    logic [2:0] isr_rank;
    logic [2:0] lvl;

    assign pending = irr & ~imr;

    // Scan from lowest rank to highest so the last hit is the winner; rank 0 is highest
    always_comb begin
        req_valid = 1'b0;
        req_level = 3'd0;
        req_rank  = 3'd0;
        isr_valid = 1'b0;
        isr_level = 3'd0;
        isr_rank  = 3'd0;
        lvl       = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            lvl = lowest + 3'(k + 1);
            if (pending[lvl]) begin
                req_valid = 1'b1;
                req_level = lvl;
                req_rank  = 3'(k);
            end
            if (isr[lvl]) begin
                isr_valid = 1'b1;
                isr_level = lvl;
                isr_rank  = 3'(k);
            end
        end
        int_req = req_valid & (~isr_valid | (req_rank < isr_rank));
    end

endmodule

// File: rtl/pic_8259a.sv
// 8259A-compatible PIC (8086 mode, single/cascade). Optional polling via OCW3 P bit
// is compiled in with the PIC_POLL_EN macro.
module pic_8259a
    import pic_8259a_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        vcc,
    input  logic        gnd,
    pic_8259a_if.slave  bus,
    inout  wire  [0:7]  data_inout,
    inout  wire  [0:2]  cas
);

    logic [1:0] cs_sync, rd_sync, wr_sync, inta_sync;
    logic [7:0] ir_sync1, ir_sync2, ir_prev, ir_vec, din;
    logic [2:0] cas_in;
    logic       wr_act_d, rd_act_d, inta_d;
    logic [2:0] state;
    logic       ic4, sngl, ltim, aeoi, rot_aeoi, ris;
    logic [4:0] vbase;
    logic [7:0] icw3, imr, isr, irr, rd_data;
    logic [2:0] lowest, ack_level;
    logic       ack_valid, cas_active, vec_drive, rd_oe, flag;
    logic [1:0] inta_cnt;
    logic       int_req, isr_valid;
    logic [2:0] req_level, isr_level;
    logic       unused_pins;
`ifdef PIC_POLL_EN
    logic       poll_armed;
`endif

    assign unused_pins = vcc ^ gnd;

    logic wr_act, wr_pulse, rd_act, rd_start, inta_low, inta_fall, inta_rise;
    logic is_master, is_slave, data_oe, cas_oe;
    logic [7:0] data_out;

    assign wr_act    = ~cs_sync[1] & ~wr_sync[1];
    assign wr_pulse  = wr_act & ~wr_act_d;
    assign rd_act    = ~cs_sync[1] & ~rd_sync[1];
    assign rd_start  = rd_act & ~rd_act_d;
    assign inta_low  = ~inta_sync[1];
    assign inta_fall = inta_low & ~inta_d;
    assign inta_rise = ~inta_low & inta_d;
    assign is_master = bus.sp_neg & ~sngl;
    assign is_slave  = ~bus.sp_neg & ~sngl;
    assign data_oe   = (rd_oe | vec_drive) & ~wr_act;
    assign cas_oe    = is_master & cas_active;
    assign data_out  = vec_drive ? compose_vector(vbase, ack_level) : rd_data;
    assign bus.interrupt_flag = flag;

    // Pins are numbered [0:7]/[0:2]; map them index-for-index onto D/IR/CAS bit numbers
    for (genvar i = 0; i < 8; i++) begin : g_bus
        assign data_inout[i] = data_oe ? data_out[i] : 1'bz;
        assign din[i]        = data_inout[i];
        assign ir_vec[i]     = bus.ir[i];
    end
    for (genvar i = 0; i < 3; i++) begin : g_cas
        assign cas[i]    = cas_oe ? ack_level[i] : 1'bz;
        assign cas_in[i] = cas[i];
    end

    pic_priority_resolver u_resolver (
        .irr       (irr),
        .imr       (imr),
        .isr       (isr),
        .lowest    (lowest),
        .int_req   (int_req),
        .req_level (req_level),
        .isr_valid (isr_valid),
        .isr_level (isr_level)
    );

    // Later assignments win: IRR tracking, then INTA, then reads, then bus writes (ICW1 aborts all)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync <= 2'b11; rd_sync <= 2'b11; wr_sync <= 2'b11; inta_sync <= 2'b11;
            ir_sync1 <= '0; ir_sync2 <= '0; ir_prev <= '0;
            wr_act_d <= 1'b0; rd_act_d <= 1'b0; inta_d <= 1'b0;
            state <= ST_IDLE;
            ic4 <= 1'b0; sngl <= 1'b0; ltim <= 1'b0; aeoi <= 1'b0; rot_aeoi <= 1'b0; ris <= 1'b0;
            vbase <= '0; icw3 <= '0; imr <= '0; isr <= '0; irr <= '0; rd_data <= '0;
            lowest <= 3'd7; ack_level <= 3'd7; ack_valid <= 1'b0;
            cas_active <= 1'b0; vec_drive <= 1'b0; rd_oe <= 1'b0; flag <= 1'b0; inta_cnt <= 2'd0;
`ifdef PIC_POLL_EN
            poll_armed <= 1'b0;
`endif
        end else begin
            cs_sync   <= {cs_sync[0], bus.cs_neg};
            rd_sync   <= {rd_sync[0], bus.rd_neg};
            wr_sync   <= {wr_sync[0], bus.wr_neg};
            inta_sync <= {inta_sync[0], bus.inta_neg};
            ir_sync1  <= ir_vec;
            ir_sync2  <= ir_sync1;
            ir_prev   <= ir_sync2;
            wr_act_d  <= wr_act;
            rd_act_d  <= rd_act;
            inta_d    <= inta_low;
            rd_oe     <= rd_act & ~wr_act;
            flag      <= int_req & (inta_cnt == 2'd0) & (state == ST_READY);

            if (ltim) irr <= ir_sync2;
            else      irr <= (irr | (ir_sync2 & ~ir_prev)) & ir_sync2;

            if (inta_fall && inta_cnt == 2'd0) begin
                inta_cnt <= 2'd1;
                if (int_req) begin
                    ack_valid  <= 1'b1;
                    ack_level  <= req_level;
                    isr[req_level] <= 1'b1;
                    if (!ltim) irr[req_level] <= 1'b0;
                    cas_active <= icw3[req_level];
                end else begin
                    ack_valid  <= 1'b0;
                    ack_level  <= 3'd7;
                    cas_active <= 1'b0;
                end
            end else if (inta_fall && inta_cnt == 2'd1) begin
                inta_cnt  <= 2'd2;
                vec_drive <= !(is_master && cas_active) && (!is_slave || cas_in == icw3[2:0]);
            end
            if (inta_rise && inta_cnt == 2'd2) begin
                inta_cnt   <= 2'd0;
                vec_drive  <= 1'b0;
                cas_active <= 1'b0;
                if (aeoi && ack_valid) begin
                    isr[ack_level] <= 1'b0;
                    if (rot_aeoi) lowest <= ack_level;
                end
            end

            if (rd_start) begin
`ifdef PIC_POLL_EN
                if (poll_armed) begin
                    poll_armed <= 1'b0;
                    rd_data    <= {int_req, 4'b0000, req_level};
                    if (int_req) begin
                        isr[req_level] <= 1'b1;
                        if (!ltim) irr[req_level] <= 1'b0;
                    end
                end else
`endif
                rd_data <= bus.a0 ? imr : (ris ? isr : irr);
            end

            if (wr_pulse) begin
                if (!bus.a0 && din[4]) begin
                    state <= ST_ICW2;
                    ic4 <= din[0]; sngl <= din[1]; ltim <= din[3];
                    imr <= '0; isr <= '0; lowest <= 3'd7;
                    aeoi <= 1'b0; rot_aeoi <= 1'b0; ris <= 1'b0;
                    inta_cnt <= 2'd0; vec_drive <= 1'b0; cas_active <= 1'b0;
`ifdef PIC_POLL_EN
                    poll_armed <= 1'b0;
`endif
                end else begin
                    case (state)
                        ST_ICW2: if (bus.a0) begin
                            vbase <= din[7:3];
                            state <= !sngl ? ST_ICW3 : (ic4 ? ST_ICW4 : ST_READY);
                        end
                        ST_ICW3: if (bus.a0) begin
                            icw3  <= din;
                            state <= ic4 ? ST_ICW4 : ST_READY;
                        end
                        ST_ICW4: if (bus.a0) begin
                            aeoi  <= din[1];
                            state <= ST_READY;
                        end
                        ST_READY: begin
                            if (bus.a0) begin
                                imr <= din;
                            end else if (din[3]) begin
                                if (din[1]) ris <= din[0];
`ifdef PIC_POLL_EN
                                poll_armed <= din[2];
`endif
                            end else begin
                                case (ocw2_cmd_t'(din[7:5]))
                                    OCW2_NS_EOI:       if (isr_valid) isr[isr_level] <= 1'b0;
                                    OCW2_S_EOI:        isr[din[2:0]] <= 1'b0;
                                    OCW2_ROT_NS_EOI:   if (isr_valid) begin
                                        isr[isr_level] <= 1'b0;
                                        lowest <= isr_level;
                                    end
                                    OCW2_ROT_S_EOI:    begin
                                        isr[din[2:0]] <= 1'b0;
                                        lowest <= din[2:0];
                                    end
                                    OCW2_SET_PRIO:     lowest <= din[2:0];
                                    OCW2_ROT_AEOI_SET: rot_aeoi <= 1'b1;
                                    OCW2_ROT_AEOI_CLR: rot_aeoi <= 1'b0;
                                    default: ;
                                endcase
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pic_8259a.sv
// Directed bench for pic_8259a: init, fully nested EOIs, rotation, masking,
// edge-triggered AEOI and reset in the middle of an INTA sequence.
module tb_pic_8259a;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vcc = 1'b1;
    logic       gnd = 1'b0;
    logic [0:7] tb_data = '0;
    logic       tb_drive = 1'b0;
    logic [7:0] obs;
    int         errors = 0;
    int         checks = 0;
    wire  [0:7] data_inout;
    wire  [0:2] cas;

    pic_8259a_if bus ();

    assign data_inout = tb_drive ? tb_data : 8'bzzzz_zzzz;

    pic_8259a dut (
        .clk        (clk),
        .rst        (rst),
        .vcc        (vcc),
        .gnd        (gnd),
        .bus        (bus),
        .data_inout (data_inout),
        .cas        (cas)
    );

    always #5 clk = ~clk;

    task automatic waitClocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // val is D-numbered: val[i] goes onto pin D i
    task automatic applyStimulus(input logic a0, input logic [7:0] val);
        bus.a0 = a0;
        for (int i = 0; i < 8; i++) tb_data[i] = val[i];
        tb_drive   = 1'b1;
        bus.cs_neg = 1'b0;
        bus.wr_neg = 1'b0;
        waitClocks(4);
        bus.wr_neg = 1'b1;
        bus.cs_neg = 1'b1;
        waitClocks(1);
        tb_drive = 1'b0;
        waitClocks(3);
    endtask

    task automatic readReg(input logic a0, output logic [7:0] val);
        bus.a0     = a0;
        bus.cs_neg = 1'b0;
        bus.rd_neg = 1'b0;
        waitClocks(5);
        for (int i = 0; i < 8; i++) val[i] = data_inout[i];
        bus.rd_neg = 1'b1;
        bus.cs_neg = 1'b1;
        waitClocks(4);
    endtask

    task automatic intaPulse(output logic [7:0] val);
        bus.inta_neg = 1'b0;
        waitClocks(5);
        for (int i = 0; i < 8; i++) val[i] = data_inout[i];
        bus.inta_neg = 1'b1;
        waitClocks(4);
    endtask

    initial begin
        bus.cs_neg = 1'b1; bus.rd_neg = 1'b1; bus.wr_neg = 1'b1;
        bus.a0 = 1'b0; bus.sp_neg = 1'b1; bus.inta_neg = 1'b1; bus.ir = '0;
        waitClocks(3);
        rst = 1'b0;
        waitClocks(3);

        checkOutput("reset_flag", {7'd0, bus.interrupt_flag}, 8'h00);
        readReg(1'b1, obs); checkOutput("reset_imr", obs, 8'h00);
        readReg(1'b0, obs); checkOutput("reset_irr", obs, 8'h00);

        // Level mode, single, IC4; base E8; 8086 mode, normal EOI
        applyStimulus(1'b0, 8'h1B);
        applyStimulus(1'b1, 8'hE8);
        applyStimulus(1'b1, 8'h01);
        bus.ir[0] = 1'b1;
        waitClocks(6);
        checkOutput("ir0_flag", {7'd0, bus.interrupt_flag}, 8'h01);
        intaPulse(obs);
        checkOutput("ir0_flag_after_inta1", {7'd0, bus.interrupt_flag}, 8'h00);
        intaPulse(obs);
        checkOutput("ir0_vector", obs, 8'hE8);
        applyStimulus(1'b0, 8'h0B);
        readReg(1'b0, obs); checkOutput("ir0_isr", obs, 8'h01);
        bus.ir[0] = 1'b0;
        waitClocks(4);
        applyStimulus(1'b0, 8'h20);
        readReg(1'b0, obs); checkOutput("ns_eoi_isr", obs, 8'h00);

        bus.ir[1] = 1'b1;
        waitClocks(6);
        checkOutput("ir1_flag", {7'd0, bus.interrupt_flag}, 8'h01);
        intaPulse(obs);
        intaPulse(obs);
        checkOutput("ir1_vector", obs, 8'hE9);
        readReg(1'b0, obs); checkOutput("ir1_isr", obs, 8'h02);
        applyStimulus(1'b0, 8'h61);
        readReg(1'b0, obs); checkOutput("s_eoi_isr", obs, 8'h00);

        // IR0 and IR1 both held: rotation moves IR0 to the bottom and back
        bus.ir[0] = 1'b1;
        waitClocks(6);
        intaPulse(obs);
        intaPulse(obs);
        checkOutput("both_vector_first", obs, 8'hE8);
        applyStimulus(1'b0, 8'hA0);
        waitClocks(6);
        checkOutput("rot_ns_flag", {7'd0, bus.interrupt_flag}, 8'h01);
        intaPulse(obs);
        intaPulse(obs);
        checkOutput("rot_ns_vector", obs, 8'hE9);
        applyStimulus(1'b0, 8'hE1);
        waitClocks(6);
        intaPulse(obs);
        intaPulse(obs);
        checkOutput("rot_s_vector", obs, 8'hE8);
        bus.ir = '0;
        waitClocks(4);
        applyStimulus(1'b0, 8'h20);
        readReg(1'b0, obs); checkOutput("final_eoi_isr", obs, 8'h00);
        waitClocks(4);
        checkOutput("idle_flag", {7'd0, bus.interrupt_flag}, 8'h00);

        // Masking
        applyStimulus(1'b1, 8'h01);
        bus.ir[0] = 1'b1;
        waitClocks(6);
        checkOutput("masked_flag", {7'd0, bus.interrupt_flag}, 8'h00);
        readReg(1'b1, obs); checkOutput("imr_read", obs, 8'h01);
        applyStimulus(1'b0, 8'h0A);
        readReg(1'b0, obs); checkOutput("masked_irr", obs, 8'h01);
        bus.ir[0] = 1'b0;
        waitClocks(4);

        // Edge-triggered with AEOI
        applyStimulus(1'b0, 8'h13);
        applyStimulus(1'b1, 8'hE8);
        applyStimulus(1'b1, 8'h03);
        bus.ir[3] = 1'b1;
        waitClocks(6);
        checkOutput("ir3_flag", {7'd0, bus.interrupt_flag}, 8'h01);
        intaPulse(obs);
        bus.ir[3] = 1'b0;
        applyStimulus(1'b0, 8'h0B);
        readReg(1'b0, obs); checkOutput("ir3_isr_mid", obs, 8'h08);
        intaPulse(obs);
        checkOutput("ir3_vector", obs, 8'hEB);
        readReg(1'b0, obs); checkOutput("aeoi_isr", obs, 8'h00);
        checkOutput("aeoi_flag", {7'd0, bus.interrupt_flag}, 8'h00);

        // Reset between the two INTA pulses
        bus.ir[3] = 1'b1;
        waitClocks(6);
        checkOutput("ir3b_flag", {7'd0, bus.interrupt_flag}, 8'h01);
        intaPulse(obs);
        readReg(1'b0, obs); checkOutput("ir3b_isr_mid", obs, 8'h08);
        bus.ir[3] = 1'b0;
        rst = 1'b1;
        waitClocks(2);
        rst = 1'b0;
        waitClocks(3);
        checkOutput("rst_mid_flag", {7'd0, bus.interrupt_flag}, 8'h00);
        readReg(1'b1, obs); checkOutput("rst_mid_imr", obs, 8'h00);
        readReg(1'b0, obs); checkOutput("rst_mid_irr", obs, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
